// File: rtl/mdu_pkg.sv
// Shared constants, op codes and FSM state type for the multiply/divide sequencer.
package mdu_pkg;

  localparam int ITERS = 32;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Combinational sign handling: operand magnitudes for PREP and result negation for FIX.
module mdu_signfix (
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        is_mult,
  input  logic        neg_q,
  input  logic        neg_r,
  output logic [31:0] rs_abs,
  output logic [31:0] rt_abs,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  logic [63:0] prod;
  logic [63:0] prod_neg;

  always_comb begin
    rs_abs   = rs[31] ? (~rs + 32'd1) : rs;
    rt_abs   = rt[31] ? (~rt + 32'd1) : rt;
    prod     = {hi_in, lo_in};
    prod_neg = ~prod + 64'd1;
    hi_out   = hi_in;
    lo_out   = lo_in;
    if (is_mult) begin
      if (neg_q) begin
        hi_out = prod_neg[63:32];
        lo_out = prod_neg[31:0];
      end
    end else begin
      // Remainder takes the dividend's sign, quotient the XOR of both signs.
      if (neg_r) hi_out = ~hi_in + 32'd1;
      if (neg_q) lo_out = ~lo_in + 32'd1;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; every add/subtract step
// goes through an external ALU driven from registered alu_* outputs.
module mdu_seq #(
  parameter int ITERS = mdu_pkg::ITERS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] mt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_fun,
  output logic        alu_sign,
  input  logic [31:0] alu_s
);
  import mdu_pkg::*;

  localparam logic [4:0] LAST_STEP = 5'(ITERS - 1);

  state_t      state_reg, state_next;
  logic [1:0]  op_reg;
  logic [4:0]  cnt_reg;
  logic [31:0] acc_reg;
  logic [31:0] mq_reg;
  logic [31:0] opnd_reg;
  logic [31:0] rs_raw_reg;
  logic        neg_q_reg, neg_r_reg, div0_reg, msb_reg;
  logic [31:0] hi_reg, lo_reg;
  logic [31:0] alu_a_reg, alu_b_reg;
  logic [5:0]  alu_fun_reg;

  logic [31:0] rs_abs, rt_abs, fix_hi, fix_lo;
  logic [31:0] rs_opnd, rt_opnd;
  logic        is_div, is_signed;

  logic        carry, borrow, take;
  logic [31:0] acc_step, mq_step;
  logic [31:0] src_acc, src_mq, src_opnd;
  logic [31:0] alu_a_next, alu_b_next;
  logic [5:0]  alu_fun_next;
  logic        msb_next;

  assign is_div    = op_is_div(op_reg);
  assign is_signed = op_is_signed(op_reg);
  assign rs_opnd   = is_signed ? rs_abs : rs_val;
  assign rt_opnd   = is_signed ? rt_abs : rt_val;

  mdu_signfix u_signfix (
    .rs      (rs_val),
    .rt      (rt_val),
    .hi_in   (acc_reg),
    .lo_in   (mq_reg),
    .is_mult (~is_div),
    .neg_q   (neg_q_reg),
    .neg_r   (neg_r_reg),
    .rs_abs  (rs_abs),
    .rt_abs  (rt_abs),
    .hi_out  (fix_hi),
    .lo_out  (fix_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_reg)
      ST_IDLE: if (start) state_next = ST_PREP;
      ST_PREP: begin
        busy       = 1'b1;
        state_next = ST_ITER;
      end
      ST_ITER: begin
        busy = 1'b1;
        if (cnt_reg == LAST_STEP) state_next = ST_FIX;
      end
      ST_FIX: begin
        busy       = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (flush && state_reg != ST_IDLE) state_next = ST_IDLE;
  end

  // One shift-add or restoring-divide step, consuming the ALU result for the registered operands.
  always_comb begin
    carry  = (alu_a_reg[31] & alu_b_reg[31]) | ((alu_a_reg[31] | alu_b_reg[31]) & ~alu_s[31]);
    borrow = (~alu_a_reg[31] & alu_b_reg[31]) | ((~alu_a_reg[31] | alu_b_reg[31]) & alu_s[31]);
    take   = msb_reg | ~borrow;
    if (is_div) begin
      acc_step = take ? alu_s : alu_a_reg;
      mq_step  = {mq_reg[30:0], take};
    end else if (mq_reg[0]) begin
      acc_step = {carry, alu_s[31:1]};
      mq_step  = {alu_s[0], mq_reg[31:1]};
    end else begin
      acc_step = {1'b0, acc_reg[31:1]};
      mq_step  = {acc_reg[0], mq_reg[31:1]};
    end
  end

  // Operands for the next ALU step come from whatever the accumulators become at this edge.
  always_comb begin
    if (state_reg == ST_PREP) begin
      src_acc  = 32'd0;
      src_mq   = is_div ? rs_opnd : rt_opnd;
      src_opnd = is_div ? rt_opnd : rs_opnd;
    end else begin
      src_acc  = acc_step;
      src_mq   = mq_step;
      src_opnd = opnd_reg;
    end
    alu_a_next   = 32'd0;
    alu_b_next   = 32'd0;
    alu_fun_next = ALU_ADD;
    msb_next     = 1'b0;
    if (state_next == ST_ITER) begin
      alu_b_next = src_opnd;
      if (is_div) begin
        alu_a_next   = {src_acc[30:0], src_mq[31]};
        alu_fun_next = ALU_SUB;
        msb_next     = src_acc[31];
      end else begin
        alu_a_next = src_acc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_reg      <= OP_MULTU;
      cnt_reg     <= 5'd0;
      acc_reg     <= 32'd0;
      mq_reg      <= 32'd0;
      opnd_reg    <= 32'd0;
      rs_raw_reg  <= 32'd0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      div0_reg    <= 1'b0;
      msb_reg     <= 1'b0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      alu_a_reg   <= 32'd0;
      alu_b_reg   <= 32'd0;
      alu_fun_reg <= ALU_ADD;
    end else begin
      alu_a_reg   <= alu_a_next;
      alu_b_reg   <= alu_b_next;
      alu_fun_reg <= alu_fun_next;
      msb_reg     <= msb_next;
      unique case (state_reg)
        ST_IDLE: begin
          if (start) op_reg <= op;
          if (mthi)  hi_reg <= mt_data;
          if (mtlo)  lo_reg <= mt_data;
        end
        ST_PREP: begin
          acc_reg    <= src_acc;
          mq_reg     <= src_mq;
          opnd_reg   <= src_opnd;
          rs_raw_reg <= rs_val;
          neg_q_reg  <= is_signed & (rs_val[31] ^ rt_val[31]);
          neg_r_reg  <= is_signed & rs_val[31];
          div0_reg   <= is_div & (rt_val == 32'd0);
          cnt_reg    <= 5'd0;
        end
        ST_ITER: begin
          acc_reg <= acc_step;
          mq_reg  <= mq_step;
          cnt_reg <= cnt_reg + 5'd1;
        end
        ST_FIX: begin
          if (!flush) begin
            hi_reg <= div0_reg ? rs_raw_reg : fix_hi;
            lo_reg <= div0_reg ? 32'hFFFF_FFFF : fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign alu_a    = alu_a_reg;
  assign alu_b    = alu_b_reg;
  assign alu_fun  = alu_fun_reg;
  assign alu_sign = 1'b0;

endmodule
